// File: rtl/rrc_tx_interp.sv
// Transmit RRC pulse shaper: one symbol per OSR clocks in, one polyphase FIR sample per clock out.
// Latency 3 clocks from phase state to data_out; sym_ready is a fixed phase decode, no backpressure on data_out.
module rrc_tx_interp #(
  parameter int WIDTH       = 7,
  parameter int COEFF_FIXED = 9,
  parameter int SYM_W       = 4,
  parameter int OSR         = 4,
  parameter int SPAN        = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic signed [SYM_W-1:0]           sym_in,
  input  logic                              sym_valid,
  output logic                              sym_ready,
  input  logic                              coef_we,
  input  logic [$clog2(OSR*SPAN)-1:0]       coef_addr,
  input  logic signed [COEFF_FIXED:0]       coef_data,
  output logic signed [WIDTH-1:0]           data_out,
  output logic                              out_valid,
  output logic                              underrun
);

  localparam int NTAP = OSR * SPAN;
  localparam int AW   = $clog2(NTAP);
  localparam int PHW  = $clog2(OSR);
  localparam int CW   = COEFF_FIXED + 1;
  localparam int PW   = SYM_W + CW;
  localparam int SW   = PW + $clog2(SPAN);
  localparam int RW   = SW + 1;

  localparam logic [PHW-1:0]       PH_LAST = PHW'(OSR - 1);
  localparam logic signed [RW-1:0] RND     = RW'(2 ** (COEFF_FIXED - 1));
  localparam logic signed [RW-1:0] SAT_HI  = RW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [RW-1:0] SAT_LO  = RW'(-(2 ** (WIDTH - 1)));

  logic [PHW-1:0]           ph_q;
  logic                     accept;
  logic signed [SYM_W-1:0]  x_q    [SPAN];
  logic signed [CW-1:0]     h_q    [NTAP];
  logic signed [CW-1:0]     hsel   [SPAN];
  logic signed [PW-1:0]     prod_d [SPAN];
  logic signed [PW-1:0]     prod_q [SPAN];
  logic signed [SW-1:0]     sum_d;
  logic signed [SW-1:0]     sum_q;
  logic signed [RW-1:0]     rnd_d;
  logic signed [WIDTH-1:0]  sat_d;
  logic signed [WIDTH-1:0]  data_q;
  logic                     started_q;
  logic                     v1_q;
  logic                     v2_q;
  logic                     ov_q;
  logic                     ur_q;

  assign accept    = (ph_q == PH_LAST);
  assign sym_ready = accept;
  assign data_out  = data_q;
  assign out_valid = ov_q;
  assign underrun  = ur_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph_q <= '0;
    end else begin
      ph_q <= accept ? '0 : ph_q + PHW'(1);
    end
  end

  // Symbol delay line; a missing symbol at the acceptance edge is replaced by zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SPAN; k++) x_q[k] <= '0;
      ur_q <= 1'b0;
    end else begin
      ur_q <= accept & ~sym_valid;
      if (accept) begin
        x_q[0] <= sym_valid ? sym_in : '0;
        for (int k = 1; k < SPAN; k++) x_q[k] <= x_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAP; i++) h_q[i] <= '0;
    end else if (coef_we) begin
      for (int i = 0; i < NTAP; i++) begin
        if (coef_addr == AW'(i)) h_q[i] <= coef_data;
      end
    end
  end

  // Polyphase tap select: branch k uses h[k*OSR + ph].
  always_comb begin
    for (int k = 0; k < SPAN; k++) begin
      hsel[k] = h_q[k*OSR];
      for (int p = 1; p < OSR; p++) begin
        if (ph_q == PHW'(p)) hsel[k] = h_q[k*OSR + p];
      end
      prod_d[k] = PW'(x_q[k]) * PW'(hsel[k]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < SPAN; k++) sum_d = sum_d + SW'(prod_q[k]);
  end

  always_comb begin
    rnd_d = (RW'(sum_q) + RND) >>> COEFF_FIXED;
    if (rnd_d > SAT_HI) begin
      sat_d = SAT_HI[WIDTH-1:0];
    end else if (rnd_d < SAT_LO) begin
      sat_d = SAT_LO[WIDTH-1:0];
    end else begin
      sat_d = rnd_d[WIDTH-1:0];
    end
  end

  // Valid tracks the first acceptance edge through the same three stages as the data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SPAN; k++) prod_q[k] <= '0;
      sum_q     <= '0;
      data_q    <= '0;
      started_q <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      for (int k = 0; k < SPAN; k++) prod_q[k] <= prod_d[k];
      sum_q     <= sum_d;
      data_q    <= sat_d;
      started_q <= started_q | accept;
      v1_q      <= started_q;
      v2_q      <= v1_q;
      ov_q      <= v2_q;
    end
  end

endmodule

// File: tb/tb_rrc_tx_interp.sv
// Scoreboard bench for rrc_tx_interp: a sum-of-products reference model queues expected samples per accepted symbol.
module tb_rrc_tx_interp;

  localparam int WIDTH = 7;
  localparam int CF    = 9;
  localparam int SYM_W = 4;
  localparam int OSR   = 4;
  localparam int SPAN  = 8;
  localparam int NTAP  = OSR * SPAN;
  localparam int YMAX  = 2 ** (WIDTH - 1) - 1;
  localparam int YMIN  = -(2 ** (WIDTH - 1));

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic signed [SYM_W-1:0]  sym_in = '0;
  logic                     sym_valid = 1'b0;
  logic                     sym_ready;
  logic                     coef_we = 1'b0;
  logic [4:0]               coef_addr = '0;
  logic [CF:0]              coef_data = '0;
  logic signed [WIDTH-1:0]  data_out;
  logic                     out_valid;
  logic                     underrun;

  rrc_tx_interp #(
    .WIDTH(WIDTH), .COEFF_FIXED(CF), .SYM_W(SYM_W), .OSR(OSR), .SPAN(SPAN)
  ) dut (
    .clk(clk), .rstn(rstn), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .data_out(data_out), .out_valid(out_valid),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge n is an acceptance edge when n is a multiple of OSR.
  int ecnt = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) ecnt = 0;
    else       ecnt = ecnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  int h_m  [NTAP];
  int hist [SPAN];
  int exp_q[$];

  function automatic void model_reset();
    foreach (h_m[i]) h_m[i] = 0;
    foreach (hist[i]) hist[i] = 0;
    exp_q.delete();
  endfunction

  function automatic void model_accept(int s);
    int acc;
    int y;
    for (int k = SPAN - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    for (int p = 0; p < OSR; p++) begin
      acc = 0;
      for (int k = 0; k < SPAN; k++) acc += h_m[k*OSR + p] * hist[k];
      y = (acc + (1 << (CF - 1))) >>> CF;
      if (y > YMAX) y = YMAX;
      if (y < YMIN) y = YMIN;
      exp_q.push_back(y);
    end
  endfunction

  // Monitor: reset state while rstn is low, otherwise out_valid timing and queued samples.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sym_ready", int'(sym_ready), 0);
        chk("rst_underrun", int'(underrun), 0);
      end else begin
        chk("out_valid", int'(out_valid), int'(ecnt >= OSR + 3));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL data_out: got %0d with no expected sample queued (t=%0t)", data_out, $time);
          end else begin
            e = exp_q.pop_front();
            chk("data_out", int'(data_out), e);
          end
        end
      end
    end
  end

  task automatic step(output bit was_acc);
    bit acc;
    bit v;
    bit we;
    int s;
    int a;
    int d;
    acc = ((ecnt + 1) % OSR == 0);
    v   = sym_valid;
    s   = int'(sym_in);
    we  = coef_we;
    a   = int'(coef_addr);
    d   = int'($signed(coef_data));
    chk("sym_ready", int'(sym_ready), int'(acc));
    @(posedge clk);
    #1;
    chk("underrun", int'(underrun), int'(acc && !v));
    if (we && a < NTAP) h_m[a] = d;
    if (acc) model_accept(v ? s : 0);
    was_acc = acc;
  endtask

  task automatic steps(int n);
    bit a;
    repeat (n) step(a);
  endtask

  task automatic slot(bit v, int s);
    bit a;
    sym_valid = v;
    sym_in    = s[SYM_W-1:0];
    a = 1'b0;
    for (int i = 0; i < OSR && !a; i++) step(a);
  endtask

  task automatic wr(int a, int d);
    bit acc;
    coef_we   = 1'b1;
    coef_addr = a[4:0];
    coef_data = d[CF:0];
    step(acc);
    coef_we   = 1'b0;
  endtask

  task automatic do_reset(int hold);
    sym_valid = 1'b0;
    coef_we   = 1'b0;
    rstn      = 1'b0;
    model_reset();
    #1;
    chk("async_rst_data_out", int'(data_out), 0);
    chk("async_rst_out_valid", int'(out_valid), 0);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
  endtask

  task automatic flush(int n);
    repeat (n) slot(1'b0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Ready cadence with sym_valid held high and zero taps.
    sym_valid = 1'b1;
    sym_in    = 4'sd5;
    steps(24);

    // Impulse and rounding.
    do_reset(2);
    for (int n = 0; n < 4; n++) wr(n, 256);
    slot(1'b1, 3);
    flush(SPAN + 2);

    // Polyphase ordering, two tap scalings.
    do_reset(2);
    for (int n = 0; n < NTAP; n++) wr(n, n);
    slot(1'b1, 7);
    flush(SPAN + 2);
    do_reset(2);
    for (int n = 0; n < NTAP; n++) wr(n, 16 * n);
    slot(1'b1, 7);
    flush(SPAN + 2);

    // Saturation and the non-saturating opposite sign.
    do_reset(2);
    for (int n = 0; n < NTAP; n++) wr(n, -512);
    repeat (SPAN + 2) slot(1'b1, -8);
    chk("sat_hi", int'(data_out), 63);
    repeat (SPAN + 2) slot(1'b1, 7);
    chk("no_sat_neg", int'(data_out), -56);
    flush(SPAN + 2);

    // Underrun in a +1 stream, then random symbols with random drops.
    do_reset(2);
    for (int n = 0; n < NTAP; n++) wr(n, int'($urandom_range(1023)) - 512);
    repeat (6) slot(1'b1, 1);
    slot(1'b0, 0);
    repeat (6) slot(1'b1, 1);
    for (int i = 0; i < 60; i++) slot($urandom_range(4) != 0, int'($urandom_range(15)) - 8);
    flush(SPAN + 2);

    // Mid-stream reset, taps cleared, then reload.
    do_reset(2);
    for (int n = 0; n < NTAP; n++) wr(n, int'($urandom_range(1023)) - 512);
    for (int i = 0; i < 12; i++) slot(1'b1, int'($urandom_range(15)) - 8);
    sym_valid = 1'b1;
    sym_in    = 4'sd6;
    steps(2);
    do_reset(3);
    for (int i = 0; i < 12; i++) slot(1'b1, int'($urandom_range(15)) - 8);
    flush(SPAN);
    for (int n = 0; n < 4; n++) wr(n, 256);
    slot(1'b1, 3);
    flush(SPAN + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
